// File: rtl/lock_seq_if.sv
// Keypad-to-lock-controller bundle: key strobes in, status/LED code out.
interface lock_seq_if #(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W  = 4,
  parameter int MAX_FAIL = 3
);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               key_clear;
  logic               lock_now;
  logic [1:0]         led_sel;
  logic               unlocked;
  logic               locked_out;
  logic [CW-1:0]      digit_cnt;
  logic [FW-1:0]      fail_cnt;

  modport master (
    output key_valid, key_digit, key_clear, lock_now,
    input  led_sel, unlocked, locked_out, digit_cnt, fail_cnt
  );
  modport slave (
    input  key_valid, key_digit, key_clear, lock_now,
    output led_sel, unlocked, locked_out, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/lock_seq_ctrl.sv
// Digital-lock sequencer: gathers keypad digits, checks them against PASSCODE,
// and times the open / error / lockout windows.
module lock_seq_ctrl #(
  parameter int                            CODE_LEN    = 4,
  parameter int                            DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   PASSCODE    = 16'h1234,
  parameter int                            MAX_FAIL    = 3,
  parameter int                            UNLOCK_CYC  = 500,
  parameter int                            ERR_CYC     = 100,
  parameter int                            LOCKOUT_CYC = 1000
) (
  input logic       clk,
  input logic       rst_n,
  lock_seq_if.slave bus
);
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int BW   = CODE_LEN * DIGIT_W;
  localparam int TMAX = (UNLOCK_CYC > ERR_CYC) ?
                        ((UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC) :
                        ((ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  logic [2:0]    r_state,     w_nxt_state;
  logic [CW-1:0] r_digit_cnt, w_nxt_digit;
  logic [FW-1:0] r_fail_cnt,  w_nxt_fail;
  logic [BW-1:0] r_buf,       w_nxt_buf;
  logic [TW-1:0] r_timer,     w_nxt_timer;
  logic [1:0]    r_led_sel,   w_nxt_led;
  logic          r_unlocked;
  logic          r_locked_out;
  logic          w_store;

  // A clear strobe always beats a digit strobe in the same cycle.
  assign w_store = bus.key_valid && !bus.key_clear;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_digit = r_digit_cnt;
    w_nxt_fail  = r_fail_cnt;
    w_nxt_buf   = r_buf;
    w_nxt_timer = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_store) begin
          w_nxt_buf = '0;
          w_nxt_buf[BW-1 -: DIGIT_W] = bus.key_digit;
          w_nxt_digit = CW'(1);
          w_nxt_state = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.key_clear) begin
          w_nxt_state = S_IDLE;
          w_nxt_digit = '0;
          w_nxt_buf   = '0;
        end else if (bus.key_valid) begin
          w_nxt_buf[(CODE_LEN-1-int'(r_digit_cnt))*DIGIT_W +: DIGIT_W] = bus.key_digit;
          w_nxt_digit = r_digit_cnt + CW'(1);
          if (r_digit_cnt == CW'(CODE_LEN-1))
            w_nxt_state = S_CHECK;
        end
      end
      S_CHECK: begin
        w_nxt_digit = '0;
        w_nxt_buf   = '0;
        if (r_buf == PASSCODE) begin
          w_nxt_state = S_OPEN;
          w_nxt_fail  = '0;
          w_nxt_timer = TW'(UNLOCK_CYC-1);
        end else if (r_fail_cnt == FW'(MAX_FAIL-1)) begin
          w_nxt_state = S_LOCKOUT;
          w_nxt_fail  = FW'(MAX_FAIL);
          w_nxt_timer = TW'(LOCKOUT_CYC-1);
        end else begin
          w_nxt_state = S_ERROR;
          w_nxt_fail  = r_fail_cnt + FW'(1);
          w_nxt_timer = TW'(ERR_CYC-1);
        end
      end
      S_OPEN: begin
        if (bus.lock_now || r_timer == '0) begin
          w_nxt_state = S_IDLE;
          w_nxt_timer = '0;
        end else
          w_nxt_timer = r_timer - TW'(1);
      end
      S_ERROR: begin
        if (r_timer == '0) w_nxt_state = S_IDLE;
        else               w_nxt_timer = r_timer - TW'(1);
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_nxt_state = S_IDLE;
          w_nxt_fail  = '0;
        end else
          w_nxt_timer = r_timer - TW'(1);
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_digit = '0;
        w_nxt_buf   = '0;
        w_nxt_timer = '0;
      end
    endcase
  end

  always_comb begin
    case (w_nxt_state)
      S_OPEN:    w_nxt_led = 2'b01;
      S_ERROR:   w_nxt_led = 2'b10;
      S_LOCKOUT: w_nxt_led = 2'b11;
      default:   w_nxt_led = 2'b00;
    endcase
  end

  // Status flags are registered off the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_digit_cnt  <= '0;
      r_fail_cnt   <= '0;
      r_buf        <= '0;
      r_timer      <= '0;
      r_led_sel    <= 2'b00;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_digit_cnt  <= w_nxt_digit;
      r_fail_cnt   <= w_nxt_fail;
      r_buf        <= w_nxt_buf;
      r_timer      <= w_nxt_timer;
      r_led_sel    <= w_nxt_led;
      r_unlocked   <= (w_nxt_state == S_OPEN);
      r_locked_out <= (w_nxt_state == S_LOCKOUT);
    end
  end

  assign bus.led_sel    = r_led_sel;
  assign bus.unlocked   = r_unlocked;
  assign bus.locked_out = r_locked_out;
  assign bus.digit_cnt  = r_digit_cnt;
  assign bus.fail_cnt   = r_fail_cnt;
endmodule
